// File: rtl/shift_src_unit.sv
// ============================================================================
// shift_src_unit : operand-channel select plus multicycle shifter with a
//                  start/busy/done handshake (SLL/SRL/SRA/ROL/ROR/pass).
// Build option   : SHIFT_SRC_FAST_EN selects a single-step barrel shifter.
// Revision       : 1.0 - initial release
// ============================================================================
`default_nettype none

module shift_src_unit #(
    parameter int WIDTH   = 32,
    parameter int NSRC    = 3,
    parameter int SEL_W   = (NSRC > 1) ? $clog2(NSRC) : 1,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    start,
    input  logic [SEL_W-1:0]        src_sel,
    input  logic [NSRC*WIDTH-1:0]   src_data,
    input  logic [SHAMT_W-1:0]      shamt,
    input  logic [2:0]              op,
    output logic                    busy,
    output logic                    done,
    output logic [WIDTH-1:0]        result,
    output logic                    sel_err
);

    localparam logic [2:0]     c_OP_SLL = 3'b000;
    localparam logic [2:0]     c_OP_SRL = 3'b001;
    localparam logic [2:0]     c_OP_SRA = 3'b010;
    localparam logic [2:0]     c_OP_ROL = 3'b011;
    localparam logic [2:0]     c_OP_ROR = 3'b100;
    localparam logic [SEL_W:0] c_NSRC   = (SEL_W+1)'(NSRC);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t             state_q;
    logic [WIDTH-1:0]   acc_q;
    logic [WIDTH-1:0]   result_q;
    logic               busy_q;
    logic               done_q;
    logic               sel_err_q;

    logic [WIDTH-1:0]   w_chan;
    logic               w_sel_bad;

    // Fully decoded mux: any select with no matching channel yields zero.
    always_comb begin
        w_chan = '0;
        for (int k = 0; k < NSRC; k++) begin
            if (src_sel == SEL_W'(k)) begin
                w_chan = src_data[k*WIDTH +: WIDTH];
            end
        end
    end

    assign w_sel_bad = ({1'b0, src_sel} >= c_NSRC);

`ifdef SHIFT_SRC_FAST_EN
    function automatic logic [WIDTH-1:0] f_barrel(input logic [WIDTH-1:0]   a,
                                                  input logic [SHAMT_W-1:0] s,
                                                  input logic [2:0]         o);
        logic [2*WIDTH-1:0] dbl;
        logic [2*WIDTH-1:0] rot;
        dbl = {a, a};
        rot = '0;
        case (o)
            c_OP_SLL: f_barrel = a << s;
            c_OP_SRL: f_barrel = a >> s;
            c_OP_SRA: f_barrel = WIDTH'($signed(a) >>> s);
            c_OP_ROL: begin
                rot      = dbl << s;
                f_barrel = rot[2*WIDTH-1 -: WIDTH];
            end
            c_OP_ROR: begin
                rot      = dbl >> s;
                f_barrel = rot[WIDTH-1:0];
            end
            default:  f_barrel = a;
        endcase
    endfunction

    logic [WIDTH-1:0] w_fast;
    assign w_fast = f_barrel(w_chan, shamt, op);
`else
    logic [SHAMT_W-1:0] cnt_q;
    logic [2:0]         op_q;
    logic [WIDTH-1:0]   w_step;
    logic               w_pass;

    function automatic logic [WIDTH-1:0] f_step(input logic [WIDTH-1:0] a,
                                                input logic [2:0]       o);
        case (o)
            c_OP_SLL: f_step = {a[WIDTH-2:0], 1'b0};
            c_OP_SRL: f_step = {1'b0, a[WIDTH-1:1]};
            c_OP_SRA: f_step = {a[WIDTH-1], a[WIDTH-1:1]};
            c_OP_ROL: f_step = {a[WIDTH-2:0], a[WIDTH-1]};
            c_OP_ROR: f_step = {a[0], a[WIDTH-1:1]};
            default:  f_step = a;
        endcase
    endfunction

    assign w_step = f_step(acc_q, op_q);
    assign w_pass = (op > c_OP_ROR);
`endif

    // result/done are loaded on the edge that enters DONE so both appear together.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            acc_q     <= '0;
            result_q  <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            sel_err_q <= 1'b0;
`ifndef SHIFT_SRC_FAST_EN
            cnt_q     <= '0;
            op_q      <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        busy_q    <= 1'b1;
                        sel_err_q <= w_sel_bad;
`ifdef SHIFT_SRC_FAST_EN
                        acc_q     <= w_fast;
                        result_q  <= w_fast;
                        done_q    <= 1'b1;
                        state_q   <= S_DONE;
`else
                        acc_q     <= w_chan;
                        cnt_q     <= shamt;
                        op_q      <= op;
                        if ((shamt == '0) || w_pass) begin
                            result_q <= w_chan;
                            done_q   <= 1'b1;
                            state_q  <= S_DONE;
                        end else begin
                            state_q  <= S_SHIFT;
                        end
`endif
                    end
                end
`ifndef SHIFT_SRC_FAST_EN
                S_SHIFT: begin
                    acc_q <= w_step;
                    cnt_q <= cnt_q - SHAMT_W'(1);
                    if (cnt_q == SHAMT_W'(1)) begin
                        result_q <= w_step;
                        done_q   <= 1'b1;
                        state_q  <= S_DONE;
                    end
                end
`endif
                S_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign result  = result_q;
    assign sel_err = sel_err_q;

endmodule

`default_nettype wire
